mux_2x1_dataflow: RTL and testbench

- 2:1 multiplexer with a continuous-assignment (dataflow) combinational output Q = s ? i1 : i0.
- Adds a registered copy of the selected data, with a valid flag and a saturating select-toggle counter, for pipelined datapaths and debug observability.
- Sits between two data sources and a downstream consumer. In the default 1-bit configuration it is a drop-in gate-level 2:1 mux.

---
 rtl/mux_2x1_dataflow_if.sv | 25 ++
 rtl/mux_2x1_dataflow.sv | 50 +++++
 tb/tb_mux_2x1_dataflow.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mux_2x1_dataflow_if.sv
// Bus bundle for mux_2x1_dataflow: the two data sources, select, capture enable
// and every mux output. The driver side is the master; the mux is the slave.
interface mux_2x1_dataflow_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             s;
    logic             en;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] q_reg;
    logic             q_valid;
    logic [CNT_W-1:0] sel_toggles;

    modport master (
        output i0, i1, s, en,
        input  Q, q_reg, q_valid, sel_toggles
    );

    modport slave (
        input  i0, i1, s, en,
        output Q, q_reg, q_valid, sel_toggles
    );
endinterface

// File: rtl/mux_2x1_dataflow.sv
// 2:1 mux with a combinational output, an enable-gated registered copy with a
// valid flag, and a saturating counter of select transitions.
module mux_2x1_dataflow #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    mux_2x1_dataflow_if.slave  bus
);
    logic [WIDTH-1:0] q_reg_q,       q_reg_d;
    logic             q_valid_q,     q_valid_d;
    logic [CNT_W-1:0] sel_toggles_q, sel_toggles_d;
    logic             s_prev_q,      s_prev_d;

    // Conditional operator merges i0/i1 bitwise when s is X/Z.
    assign bus.Q = bus.s ? bus.i1 : bus.i0;

    always_comb begin
        q_reg_d       = q_reg_q;
        q_valid_d     = q_valid_q;
        sel_toggles_d = sel_toggles_q;
        s_prev_d      = bus.s;
        if (bus.en) begin
            q_reg_d   = bus.s ? bus.i1 : bus.i0;
            q_valid_d = 1'b1;
        end
        if ((bus.s != s_prev_q) && (sel_toggles_q != '1)) begin
            sel_toggles_d = sel_toggles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg_q       <= '0;
            q_valid_q     <= 1'b0;
            sel_toggles_q <= '0;
            s_prev_q      <= 1'b0;
        end else begin
            q_reg_q       <= q_reg_d;
            q_valid_q     <= q_valid_d;
            sel_toggles_q <= sel_toggles_d;
            s_prev_q      <= s_prev_d;
        end
    end

    assign bus.q_reg       = q_reg_q;
    assign bus.q_valid     = q_valid_q;
    assign bus.sel_toggles = sel_toggles_q;
endmodule

// File: tb/tb_mux_2x1_dataflow.sv
// Directed bench: 1-bit mux (8-bit counter), 1-bit mux (2-bit counter) and
// 8-bit mux share one clock and reset.
module tb_mux_2x1_dataflow;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    mux_2x1_dataflow_if #(.WIDTH(1), .CNT_W(8)) a_if ();
    mux_2x1_dataflow_if #(.WIDTH(1), .CNT_W(2)) b_if ();
    mux_2x1_dataflow_if #(.WIDTH(8), .CNT_W(8)) w_if ();

    mux_2x1_dataflow #(.WIDTH(1), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    mux_2x1_dataflow #(.WIDTH(1), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
    mux_2x1_dataflow #(.WIDTH(8), .CNT_W(8)) u_w (.clk(clk), .rst(rst), .bus(w_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] tt_in  [8];
        logic       tt_q   [8];
        logic [2:0] v;
        passed = 0;
        total  = 0;
        // {i0, i1, s} vectors and expected Q
        tt_in = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
        tt_q  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        a_if.i0 = '0; a_if.i1 = '0; a_if.s = 1'b0; a_if.en = 1'b0;
        b_if.i0 = '0; b_if.i1 = '0; b_if.s = 1'b0; b_if.en = 1'b0;
        w_if.i0 = '0; w_if.i1 = '0; w_if.s = 1'b0; w_if.en = 1'b0;

        for (int k = 0; k < 8; k++) begin
            v = tt_in[k];
            a_if.i0 = v[2]; a_if.i1 = v[1]; a_if.s = v[0];
            #10;
            check($sformatf("truth_%0d", k), {31'd0, a_if.Q}, {31'd0, tt_q[k]});
        end

        // Reset and first capture
        @(negedge clk);
        rst = 1'b1; a_if.s = 1'b0; a_if.en = 1'b1; a_if.i0 = 1'b1; a_if.i1 = 1'b0;
        edge_sample();
        check("rst_q_reg", {31'd0, a_if.q_reg}, 32'd0);
        check("rst_q_valid", {31'd0, a_if.q_valid}, 32'd0);
        check("rst_toggles", {24'd0, a_if.sel_toggles}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        check("cap_q_reg", {31'd0, a_if.q_reg}, 32'd1);
        check("cap_q_valid", {31'd0, a_if.q_valid}, 32'd1);
        @(negedge clk);
        a_if.s = 1'b1;
        edge_sample();
        check("sel1_q_reg", {31'd0, a_if.q_reg}, 32'd0);
        check("sel1_toggles", {24'd0, a_if.sel_toggles}, 32'd1);

        // Enable hold
        @(negedge clk);
        a_if.s = 1'b0;
        edge_sample();
        check("hold_pre_q_reg", {31'd0, a_if.q_reg}, 32'd1);
        @(negedge clk);
        a_if.en = 1'b0; a_if.i0 = 1'b0; a_if.i1 = 1'b0;
        #1;
        check("hold_Q_now", {31'd0, a_if.Q}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            edge_sample();
            check($sformatf("hold_q_reg_%0d", k), {31'd0, a_if.q_reg}, 32'd1);
        end
        check("hold_q_valid", {31'd0, a_if.q_valid}, 32'd1);
        check("hold_toggles", {24'd0, a_if.sel_toggles}, 32'd2);

        // Toggle counter and saturation
        @(negedge clk);
        rst = 1'b1; a_if.s = 1'b0; b_if.s = 1'b0;
        a_if.en = 1'b1; a_if.i0 = 1'b1; a_if.i1 = 1'b1;
        edge_sample();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_if.s = ~a_if.s; b_if.s = ~b_if.s;
            edge_sample();
            if (k == 2) check("sat_b_3", {24'd0, 6'd0, b_if.sel_toggles}, 32'd3);
            @(negedge clk);
        end
        check("toggles_a_5", {24'd0, a_if.sel_toggles}, 32'd5);
        a_if.s = ~a_if.s; b_if.s = ~b_if.s;
        edge_sample();
        check("toggles_a_6", {24'd0, a_if.sel_toggles}, 32'd6);
        check("sat_b_6", {24'd0, 6'd0, b_if.sel_toggles}, 32'd3);
        check("pre_rst_valid", {31'd0, a_if.q_valid}, 32'd1);

        // Reset beats enable
        @(negedge clk);
        rst = 1'b1; a_if.en = 1'b1; a_if.i1 = 1'b1; a_if.i0 = 1'b0; a_if.s = 1'b1;
        #1;
        check("prio_Q_before", {31'd0, a_if.Q}, 32'd1);
        edge_sample();
        check("prio_q_reg", {31'd0, a_if.q_reg}, 32'd0);
        check("prio_q_valid", {31'd0, a_if.q_valid}, 32'd0);
        check("prio_toggles", {24'd0, a_if.sel_toggles}, 32'd0);
        check("prio_Q_after", {31'd0, a_if.Q}, 32'd1);

        // Wide data path
        @(negedge clk);
        rst = 1'b0;
        w_if.en = 1'b1; w_if.i0 = 8'hA5; w_if.i1 = 8'h3C; w_if.s = 1'b0;
        #1;
        check("wide_Q_i0", {24'd0, w_if.Q}, 32'hA5);
        edge_sample();
        check("wide_q_reg_i0", {24'd0, w_if.q_reg}, 32'hA5);
        @(negedge clk);
        w_if.s = 1'b1;
        #1;
        check("wide_Q_i1", {24'd0, w_if.Q}, 32'h3C);
        check("wide_q_reg_lag", {24'd0, w_if.q_reg}, 32'hA5);
        edge_sample();
        check("wide_q_reg_i1", {24'd0, w_if.q_reg}, 32'h3C);
        check("wide_toggles", {24'd0, w_if.sel_toggles}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
